debug_reg_scanner: RTL and testbench

//  Sits downstream of the single-cycle processor's debug register port: drives the 4-bit register select,

---
 rtl/debug_reg_scanner_if.sv | 28 ++
 rtl/debug_reg_scanner.sv | 171 +++++++++++++++++
 tb/tb_debug_reg_scanner.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_reg_scanner_if.sv
// debug_reg_scanner_if
//   Bundles the two buses of the debug register scanner:
//     - processor debug port: dbg_sel (scanner -> cpu), dbg_val (cpu -> scanner,
//       combinational from dbg_sel)
//     - beat stream to the trace sink: out_valid/out_idx/out_data (scanner -> sink),
//       out_ready (sink -> scanner)
//   master: scanner side.  slave: processor + sink side (bench / board glue).
interface debug_reg_scanner_if #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 32
);
  logic [SEL_W-1:0]  dbg_sel;
  logic [DATA_W-1:0] dbg_val;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output dbg_sel, out_valid, out_idx, out_data,
    input  dbg_val, out_ready
  );

  modport slave (
    input  dbg_sel, out_valid, out_idx, out_data,
    output dbg_val, out_ready
  );
endinterface

// File: rtl/debug_reg_scanner.sv
// debug_reg_scanner
//   Steps the processor debug register select through R0..R(NUM_REGS-1), snapshots
//   each value, then streams the snapshot as (index, value) beats on a valid/ready
//   handshake.
//   Ports:
//     clk     rising-edge clock (processor clock)
//     reset   asynchronous, active-low
//     start   1-cycle pulse, begins a snapshot when idle
//     abort   drop the current scan/drain, back to idle next edge
//     bus     debug_reg_scanner_if.master (dbg_sel/dbg_val, out_* stream)
//     busy    1 while scanning or draining
//     done    1-cycle pulse after the final beat is accepted
//     missed  sticky: start seen while busy; cleared only by reset
//   Build option DBG_SCAN_CHANGED_EN: keep the previous delivered snapshot and emit
//   only entries that differ from it (all entries while no previous snapshot exists).
module debug_reg_scanner #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int DATA_W   = 32,
  parameter int SETTLE   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  debug_reg_scanner_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                missed
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam int               PW       = SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);
  localparam logic [2:0]       SETTLE_C = 3'(SETTLE);

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [2:0]          wcnt;
  logic [PW-1:0]       ptr;      // lowest index not yet delivered
  logic [DATA_W-1:0]   snap [NUM_REGS];
  logic [NUM_REGS-1:0] emit;     // entries eligible for output this snapshot
  logic [SEL_W-1:0]    nxt;      // entry currently presented
  logic                have_nxt;
  logic                have_more;
  logic                sample;
  logic                hs;
  logic                finish;

  assign sample = (state == SCAN) && (wcnt == SETTLE_C);
  assign hs     = (state == DRAIN) && have_nxt && bus.out_ready;
  // Drain ends on the last handshake, or at once when nothing is eligible.
  // abort wins over a same-cycle handshake.
  assign finish = (state == DRAIN) && !abort && (!have_nxt || (hs && !have_more));

  // First eligible entry at/after ptr, and whether another one follows it.
  always_comb begin
    nxt       = '0;
    have_nxt  = 1'b0;
    have_more = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (emit[k] && (PW'(k) >= ptr)) begin
        if (!have_nxt) begin
          nxt      = SEL_W'(k);
          have_nxt = 1'b1;
        end else begin
          have_more = 1'b1;
        end
      end
    end
  end

  // Stream outputs decode straight from registered state, so the beat is stable
  // while stalled and the next entry appears the cycle after a handshake.
  assign bus.dbg_sel   = sel;
  assign bus.out_valid = (state == DRAIN) && have_nxt;
  assign bus.out_idx   = bus.out_valid ? nxt : '0;
  assign bus.out_data  = bus.out_valid ? snap[nxt] : '0;

  // Snapshot storage is not reset.
  always_ff @(posedge clk) begin
    if (sample) snap[sel] <= bus.dbg_val;
  end

`ifdef DBG_SCAN_CHANGED_EN
  logic              prev_valid;
  logic [DATA_W-1:0] prev [NUM_REGS];

  always_comb begin
    emit = '0;
    for (int k = 0; k < NUM_REGS; k++)
      emit[k] = !prev_valid || (snap[k] != prev[k]);
  end

  // Only a completed delivery updates the reference; abort leaves it alone.
  always_ff @(posedge clk) begin
    if (finish)
      for (int k = 0; k < NUM_REGS; k++) prev[k] <= snap[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      prev_valid <= 1'b0;
    else if (finish) prev_valid <= 1'b1;
  end
`else
  assign emit = '1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= '0;
      wcnt   <= '0;
      ptr    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      missed <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (state != IDLE)) missed <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            sel   <= '0;
            wcnt  <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            sel   <= '0;
          end else if (sample) begin
            wcnt <= '0;
            if (sel == LAST_SEL) begin
              sel   <= '0;
              ptr   <= '0;
              state <= DRAIN;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            sel   <= '0;
          end else if (finish) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (hs) begin
            ptr <= PW'(nxt) + PW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sel   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_reg_scanner.sv
module tb_debug_reg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic        busy, done, missed;
  logic [31:0] model [16];
  logic [35:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  debug_reg_scanner_if #(.SEL_W(4), .DATA_W(32)) bus ();

  assign bus.dbg_val   = model[bus.dbg_sel];
  assign bus.out_ready = ready;

  debug_reg_scanner #(.NUM_REGS(16), .SEL_W(4), .DATA_W(32), .SETTLE(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .bus    (bus.master),
    .busy   (busy),
    .done   (done),
    .missed (missed)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic set_model(input logic [31:0] base);
    for (int k = 0; k < 16; k++) model[k] = base + 32'(k);
  endtask

  task automatic load_all();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), model[k]});
  endtask

  // Runs one snapshot (already started) to its done pulse, checking beats
  // against exp_q. mode 1 drives out_ready with the repeating 1,0,0,1 pattern.
  task automatic drain(input string tag, input int mode);
    int          cyc;
    bit          got;
    logic [3:0]  ei;
    logic [31:0] ed;
    cyc = 0;
    got = 0;
    while (cyc < 200 && !got) begin
      ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (bus.out_valid) begin
        chk({tag, " beat expected"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          {ei, ed} = exp_q[0];
          chk({tag, " idx"}, 64'(bus.out_idx), 64'(ei));
          chk({tag, " data"}, 64'(bus.out_data), 64'(ed));
          if (ready) void'(exp_q.pop_front());
        end
      end
      tick();
      cyc++;
      if (done) got = 1;
    end
    ready = 1'b1;
    chk({tag, " done seen"}, 64'(got), 64'd1);
    chk({tag, " beats left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    set_model(32'h1000);

    // 1: reset held two cycles with start high
    reset = 1'b1;
    #2;
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst busy", 64'(busy), 0);
      chk("rst done", 64'(done), 0);
      chk("rst missed", 64'(missed), 0);
      chk("rst valid", 64'(bus.out_valid), 0);
      chk("rst idx", 64'(bus.out_idx), 0);
      chk("rst data", 64'(bus.out_data), 0);
      chk("rst sel", 64'(bus.dbg_sel), 0);
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    chk("post-rst idle", 64'(busy), 0);

    // 2: full scan, always ready, exact timing
    do_reset();
    ready = 1'b1;
    pulse_start();
    chk("s2 busy", 64'(busy), 1);
    chk("s2 sel0", 64'(bus.dbg_sel), 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("s2 sel%0d", k), 64'(bus.dbg_sel), 64'(k));
      chk("s2 no valid in scan", 64'(bus.out_valid), 0);
    end
    tick();
    chk("s2 drain sel", 64'(bus.dbg_sel), 0);
    for (int b = 0; b < 16; b++) begin
      chk("s2 valid", 64'(bus.out_valid), 1);
      chk("s2 idx", 64'(bus.out_idx), 64'(b));
      chk("s2 data", 64'(bus.out_data), 64'(32'h1000 + b));
      chk("s2 no early done", 64'(done), 0);
      tick();
    end
    chk("s2 done", 64'(done), 1);
    chk("s2 busy0", 64'(busy), 0);
    chk("s2 valid0", 64'(bus.out_valid), 0);
    tick();
    chk("s2 done once", 64'(done), 0);

    // 3: backpressure on a fresh snapshot
    do_reset();
    set_model(32'h3000);
    load_all();
    pulse_start();
    drain("s3", 1);

    // 4: start during scan and on the final handshake
    do_reset();
    set_model(32'h1000);
    chk("s4 missed clear", 64'(missed), 0);
    ready = 1'b1;
    pulse_start();
    for (int k = 1; k < 16; k++) begin
      start = (k == 5);
      tick();
      start = 1'b0;
    end
    chk("s4 missed set", 64'(missed), 1);
    tick();
    for (int b = 0; b < 16; b++) begin
      chk("s4 idx", 64'(bus.out_idx), 64'(b));
      chk("s4 data", 64'(bus.out_data), 64'(32'h1000 + b));
      start = (b == 15);
      tick();
      start = 1'b0;
    end
    chk("s4 done", 64'(done), 1);
    chk("s4 start ignored", 64'(busy), 0);
    tick();
    chk("s4 still idle", 64'(busy), 0);
    chk("s4 missed sticky", 64'(missed), 1);

    // 5: abort on beat 5, then a fresh full scan
    do_reset();
    ready = 1'b1;
    pulse_start();
    begin
      bit found;
      found = 0;
      for (int c = 0; c < 60; c++) begin
        if (bus.out_valid && bus.out_idx == 4'd5) begin
          found = 1;
          break;
        end
        tick();
      end
      chk("s5 reached beat5", 64'(found), 1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5 valid0", 64'(bus.out_valid), 0);
    chk("s5 busy0", 64'(busy), 0);
    chk("s5 no done", 64'(done), 0);
    chk("s5 sel0", 64'(bus.dbg_sel), 0);
    tick();
    chk("s5 no done later", 64'(done), 0);
    set_model(32'h5000);
    load_all();
    pulse_start();
    drain("s5 rescan", 0);

`ifdef DBG_SCAN_CHANGED_EN
    // 6: only changed entries are emitted
    do_reset();
    set_model(32'h1000);
    load_all();
    pulse_start();
    drain("s6 snap1", 0);
    model[2] = 32'hDEADBEEF;
    exp_q.delete();
    exp_q.push_back({4'd2, 32'hDEADBEEF});
    pulse_start();
    drain("s6 snap2", 0);
    pulse_start();
    repeat (16) tick();
    chk("s6 snap3 no beat", 64'(bus.out_valid), 0);
    chk("s6 snap3 busy", 64'(busy), 1);
    tick();
    chk("s6 snap3 done", 64'(done), 1);
    chk("s6 snap3 idle", 64'(busy), 0);
`endif

    // missed only clears on reset
    do_reset();
    chk("missed reset", 64'(missed), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
